// File: rtl/seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_multiplier                                               |
// | Description : Iterative add-shift multiplier, one partial product per      |
// |               cycle, WIDTH cycles from accept to result. Optional two's    |
// |               complement mode enabled by defining MULT_SIGNED_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  input  logic                 i_signed,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int                 c_CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_sext;
  logic                 w_neg_step;

  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;

  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_last = (r_state == S_COMPUTE) && (r_cnt == c_LAST_STEP);

`ifdef MULT_SIGNED_EN
  logic r_signed;

  // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so the
  // final step subtracts its partial product instead of adding it.
  assign w_sext     = i_signed & i_multiplicand[WIDTH-1];
  assign w_neg_step = r_signed & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= i_signed;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = i_signed;
  assign w_sext          = 1'b0;
  assign w_neg_step      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_COMPUTE;
          w_accept     = 1'b1;
        end
      end
      S_COMPUTE: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Holding start keeps us here so a long request is one operation.
        if (!i_start) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = w_neg_step ? (r_acc - w_addend) : (r_acc + w_addend);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{w_sext}}, i_multiplicand};
      r_mplier <= i_multiplier;
      r_acc    <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_cnt    <= r_cnt + c_CNT_ONE;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
      // Only the completed sum reaches the output register.
      if (w_last) begin
        r_product <= w_acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_COMPUTE);
      r_done <= (w_state_next == S_DONE);
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

`default_nettype wire
